// File: rtl/quad_step_sequencer.sv
// quad_step_sequencer
// Emits a requested number of Gray-coded A/B quadrature steps in a chosen
// direction. Each phase is held for HOLD_CYCLES clocks so a downstream decoder
// with 2-flop input synchronisers observes every phase.
// io_in : [0] clk, [1] rst_n, [2] start, [3] dir, [7:4] step count (0 = 16)
// io_out: [1:0] phase {A,B}, [2] busy, [3] done, [7:4] remaining[3:0]
module quad_step_sequencer #(
  parameter int HOLD_CYCLES = 4,
  parameter int DWELL_W     = 3
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [DWELL_W-1:0] DWELL_RELOAD = DWELL_W'(HOLD_CYCLES - 1);

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       dir_in;
  logic [3:0] count_in;

  assign clk      = io_in[0];
  assign rst_n    = io_in[1];
  assign start    = io_in[2];
  assign dir_in   = io_in[3];
  assign count_in = io_in[7:4];

  logic [1:0]         state;
  logic               start_q;
  logic               dir_q;
  logic [1:0]         phase;
  logic [4:0]         remaining;
  logic [DWELL_W-1:0] dwell;

  logic               accept;
  logic [1:0]         phase_next;
  logic [4:0]         remaining_dec;

  // Rising edge of start, honoured only while idle; anything else is dropped.
  always_comb begin
    accept = start & ~start_q & (state == S_IDLE);
  end

  // Next Gray phase in the latched direction (forward 00>01>11>10>00).
  always_comb begin
    phase_next = phase;
    if (dir_q) begin
      case (phase)
        2'b00:   phase_next = 2'b01;
        2'b01:   phase_next = 2'b11;
        2'b11:   phase_next = 2'b10;
        default: phase_next = 2'b00;
      endcase
    end else begin
      case (phase)
        2'b00:   phase_next = 2'b10;
        2'b10:   phase_next = 2'b11;
        2'b11:   phase_next = 2'b01;
        default: phase_next = 2'b00;
      endcase
    end
  end

  // Remaining count after the step that is about to be taken.
  always_comb begin
    remaining_dec = remaining - 5'd1;
  end

  // Sequencer state, dwell timer, phase and step bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      start_q   <= 1'b1;   // a start held through reset must not look like an edge
      dir_q     <= 1'b0;
      phase     <= 2'b00;
      remaining <= '0;
      dwell     <= '0;
    end else begin
      start_q <= start;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state     <= S_RUN;
            dir_q     <= dir_in;
            remaining <= (count_in == 4'd0) ? 5'd16 : {1'b0, count_in};
            dwell     <= DWELL_RELOAD;
          end
        end
        S_RUN: begin
          if (dwell != '0) begin
            dwell <= dwell - 1'b1;
          end else begin
            phase     <= phase_next;
            remaining <= remaining_dec;
            if (remaining_dec == 5'd0) begin
              state <= S_DONE;
            end else begin
              dwell <= DWELL_RELOAD;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign io_out = {remaining[3:0], (state == S_DONE), (state == S_RUN), phase};

endmodule

// File: tb/tb_quad_step_sequencer.sv
// Testbench for quad_step_sequencer: expected io_out bytes are scheduled in a
// queue at the cycle they must appear and compared as the DUT reaches them.
module tb_quad_step_sequencer;

  localparam int H = 4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       dir;
  logic [3:0] cnt;
  logic [7:0] io_in;
  logic [7:0] io_out;

  assign io_in = {cnt, dir, start, rst_n, clk};

  quad_step_sequencer #(.HOLD_CYCLES(H), .DWELL_W(3)) dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: after posedge n, cyc == n.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [7:0] v;
    string      tag;
  } exp_t;

  exp_t q[$];
  exp_t head;

  int    n_checks = 0;
  int    n_errors = 0;
  string cur_tag  = "";
  logic [1:0] ph  = 2'b00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Gray step via binary conversion.
  function automatic logic [1:0] gstep(input logic [1:0] g, input logic d);
    logic [1:0] b;
    b = {g[1], g[1] ^ g[0]};
    b = d ? b + 2'd1 : b - 2'd1;
    return {b[1], b[1] ^ b[0]};
  endfunction

  function automatic logic [7:0] pack(input int rem, input logic done, input logic busy,
                                      input logic [1:0] p);
    logic [4:0] r;
    r = 5'(rem);
    return {r[3:0], done, busy, p};
  endfunction

  task automatic push(input int c, input logic [7:0] v, input int upto);
    exp_t e;
    if (c <= upto) begin
      e.c   = c;
      e.v   = v;
      e.tag = $sformatf("%s@%0d", cur_tag, c);
      q.push_back(e);
    end
  endtask

  // Schedule the full expected trace of a run accepted at edge e.
  task automatic push_run(input int e, input int n, input logic d, input int upto);
    push(e, pack(n, 1'b0, 1'b1, ph), upto);
    for (int k = 1; k <= n; k++) begin
      push(e + k*H - 1, pack(n - k + 1, 1'b0, 1'b1, ph), upto);
      ph = gstep(ph, d);
      push(e + k*H, pack(n - k, (k == n), (k < n), ph), upto);
    end
    for (int j = 1; j <= 4; j++)
      push(e + n*H + j, pack(0, 1'b0, 1'b0, ph), upto);
  endtask

  // Compare scheduled expectations when the DUT reaches their cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].c <= cyc) begin
      head = q.pop_front();
      check(head.tag, io_out, head.v);
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      check({cur_tag, "_timeout"}, q.size(), 0);
      q.delete();
    end
  endtask

  task automatic run(input logic [3:0] c, input logic d);
    int n;
    int e;
    n = (c == 4'd0) ? 16 : int'(c);
    @(negedge clk);
    cnt = c; dir = d; start = 1'b1;
    e = cyc + 1;
    push_run(e, n, d, 1 << 30);
    @(negedge clk);
    start = 1'b0;
    drain(n*H + 20);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check({cur_tag, "_reset"}, io_out, 0);
    rst_n = 1'b1;
    ph = 2'b00;
  endtask

  initial begin
    int e;
    rst_n = 1'b0; start = 1'b1; dir = 1'b0; cnt = 4'd0;

    // T1: reset with start held high, then release with start still high
    cur_tag = "T1";
    repeat (2) @(negedge clk);
    check("T1_reset_io", io_out, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("T1_busy_%0d", i), io_out[2], 1'b0);
    end
    start = 1'b0;
    @(negedge clk);

    // T2: forward 3 steps from 00
    cur_tag = "T2";
    run(4'd3, 1'b1);

    // T3: reverse 2 steps from 10
    cur_tag = "T3";
    run(4'd2, 1'b0);

    // T4: count 0 = 16 forward steps from 00
    cur_tag = "T4";
    do_reset();
    run(4'd0, 1'b1);

    // T5: start re-pulse at edge 5 and dir toggle at edge 6 are ignored
    cur_tag = "T5";
    @(negedge clk);
    cnt = 4'd3; dir = 1'b1; start = 1'b1;
    e = cyc + 1;
    push_run(e, 3, 1'b1, 1 << 30);
    @(negedge clk);
    start = 1'b0;
    wait_cyc(e + 4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dir = 1'b0;
    drain(3*H + 20);

    // T6: reset asserted at edge 6 of a count=5 run
    cur_tag = "T6";
    @(negedge clk);
    cnt = 4'd5; dir = 1'b1; start = 1'b1;
    e = cyc + 1;
    push_run(e, 5, 1'b1, e + 5);
    @(negedge clk);
    start = 1'b0;
    wait_cyc(e + 5);
    rst_n = 1'b0;
    @(negedge clk);
    check("T6_abort_io", io_out, 0);
    rst_n = 1'b1;
    ph = 2'b00;
    drain(10);
    @(negedge clk);
    check("T6_after_busy", io_out[2], 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
